// File: rtl/seq_divider_nbits.sv
// Sequential restoring divider: one quotient bit per clock, registered Q/R.
// Optional signed divide is enabled by defining SEQ_DIVIDER_SIGNED_EN.
module seq_divider_nbits #(
    parameter int bits = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            signed_op,
    input  logic [bits-1:0] A,
    input  logic [bits-1:0] B,
    output logic [bits-1:0] Q,
    output logic [bits-1:0] R,
    output logic            busy,
    output logic            done,
    output logic            div_zero
);

    localparam int CW = $clog2(bits);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [bits-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q_q, neg_r_q;

    logic            sa, sb;
    logic [bits-1:0] a_mag, b_mag;
    logic [bits:0]   trial;
    logic [bits+1:0] sub;
    logic            no_borrow;
    logic [bits-1:0] rem_nx, quo_nx, q_fin, r_fin;
    logic            last;
    logic            unused_ok;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign sa = signed_op & A[bits-1];
    assign sb = signed_op & B[bits-1];
`else
    assign sa = 1'b0;
    assign sb = 1'b0;
`endif

    // Magnitudes at load; the most-negative value maps onto itself, which is
    // already its correct unsigned magnitude.
    assign a_mag = sa ? (~A + bits'(1)) : A;
    assign b_mag = sb ? (~B + bits'(1)) : B;

    // Trial subtract in A + ~B + 1 form; the carry out is the inverted borrow.
    assign trial     = {rem_q, quo_q[bits-1]};
    assign sub       = {1'b0, trial} + {1'b0, ~{1'b0, dvs_q}} + (bits+2)'(1);
    assign no_borrow = sub[bits+1];
    assign rem_nx    = no_borrow ? sub[bits-1:0] : trial[bits-1:0];
    assign quo_nx    = {quo_q[bits-2:0], no_borrow};
    assign q_fin     = neg_q_q ? (~quo_nx + bits'(1)) : quo_nx;
    assign r_fin     = neg_r_q ? (~rem_nx + bits'(1)) : rem_nx;
    assign last      = (cnt_q == CW'(bits-1));
    assign unused_ok = ^{sub[bits], signed_op};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (B == '0) ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem_q   <= '0;
                        quo_q   <= a_mag;
                        dvs_q   <= b_mag;
                        cnt_q   <= '0;
                        neg_q_q <= sa ^ sb;
                        neg_r_q <= sa;
                        // Divide by zero skips CALC, so results land here.
                        if (B == '0) begin
                            Q        <= '1;
                            R        <= A;
                            div_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        Q        <= q_fin;
                        R        <= r_fin;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_nbits.sv
// Directed self-checking bench for seq_divider_nbits (bits = 32).
// Signed vectors are selected by SEQ_DIVIDER_SIGNED_EN, matching the DUT build.
module tb_seq_divider_nbits;

    logic        clk = 1'b0;
    logic        rst_n, start, signed_op;
    logic [31:0] A, B, Q, R;
    logic        busy, done, div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider_nbits #(.bits(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .signed_op(signed_op),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Present a request so the following rising edge accepts it.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; signed_op = s; A = a; B = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Latency counted in cycles after the accepting edge; capped at 100.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 100);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int lat;
        launch(s, a, b);
        wait_done(lat);
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".Q"}, Q, eq);
        check({tag, ".R"}, R, er);
        check({tag, ".dz"}, div_zero, edz);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 1'b0);
        check({tag, ".idle"}, busy, 1'b0);
    endtask

    initial begin
        int lat;
        int dones;
        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.Q", Q, 0);
        check("rst.R", R, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.dz", div_zero, 0);
        rst_n = 1'b1;

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
        run_op("div0", 1'b0, 32'hFFFF_FFFF, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // Second start 5 cycles into CALC must be ignored.
        launch(1'b0, 32'd50, 32'd5);
        repeat (4) @(negedge clk);
        check("busy_mid", busy, 1'b1);
        start = 1'b1; A = 32'd9; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 100);
        check("ign.lat", lat, 33);
        check("ign.Q", Q, 32'd10);
        check("ign.R", R, 32'd0);
        check("ign.dz", div_zero, 1'b0);

        // Results hold while a later operation runs.
        launch(1'b0, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        check("hold.Q", Q, 32'd10);
        check("hold.R", R, 32'd0);
        wait_done(lat);
        check("hold.lat", lat, 23);
        check("k1000_3.Q", Q, 32'd333);
        check("k1000_3.R", R, 32'd1);

        // Start during the done cycle is ignored; accepted one cycle later.
        launch(1'b0, 32'd9, 32'd3);
        wait_done(lat);
        check("k9_3.Q", Q, 32'd3);
        start = 1'b1; A = 32'd20; B = 32'd4;
        @(negedge clk);
        check("done_start.busy", busy, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        check("k20_4.lat", lat, 33);
        check("k20_4.Q", Q, 32'd5);
        check("k20_4.R", R, 32'd0);

        run_op("lt", 1'b0, 32'd3, 32'd10, 33, 32'd0, 32'd3, 1'b0);
        run_op("maxmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'd1, 32'd0, 1'b0);
        run_op("maxby1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("zero_a", 1'b0, 32'd0, 32'd5, 33, 32'd0, 32'd0, 1'b0);
        run_op("big", 1'b0, 32'hDEAD_BEEF, 32'h0001_0000, 33, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_op("s_div0", 1'b1, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
`else
        run_op("nos_op", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

        // Reset 10 cycles into CALC aborts the operation.
        launch(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.busy", busy, 1'b0);
        check("abort.Q", Q, 32'd0);
        check("abort.R", R, 32'd0);
        check("abort.done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort.no_done", dones, 0);
        run_op("post_rst", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
